// File: rtl/nand_op_sequencer_if.sv
// nand_op_sequencer_if: host request channel of the NAND operation sequencer.
//
// Signals:
//   req_valid  host -> seq  request strobe
//   req_ready  seq -> host  sequencer idle, request accepted when both high
//   req_op     host -> seq  0 = page read, 1 = block erase
//   req_addr   host -> seq  [15:0] column, [39:16] row
//   busy       seq -> host  high from accept until done
//   done       seq -> host  one-clock completion pulse
//
// Modports: master = host side, slave = sequencer side.
interface nand_op_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [39:0] req_addr;
    logic        busy;
    logic        done;

    modport master (
        output req_valid, req_op, req_addr,
        input  req_ready, busy, done
    );

    modport slave (
        input  req_valid, req_op, req_addr,
        output req_ready, busy, done
    );
endinterface

// File: rtl/nand_op_sequencer.sv
// nand_op_sequencer: drives one complete NAND page-read or block-erase bus
// sequence (command, address, confirm command, ready/busy wait) per request.
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous reset, active-high
//   host      request channel (nand_op_sequencer_if.slave)
//   RB        NAND ready/busy, low = busy, asynchronous to clk
//   CE        chip enable, active-low
//   CLE       command latch enable
//   ALE       address latch enable
//   WE        write enable, active-low
//   IOX[7:0]  NAND data bus
//   timeout   only with NAND_RB_TIMEOUT_EN: high with done when RB never rose
//
// Build option: define NAND_RB_TIMEOUT_EN to bound the ready/busy wait to
// RB_TIMEOUT clocks.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for a request, req_ready high
// CMD1    | one bus cycle, 00h (read) or 60h (erase) with CLE
// ADDR    | 5 (read) or 3 (erase) address bus cycles with ALE
// CMD2    | one bus cycle, 30h (read) or D0h (erase) with CLE
// WAIT_WB | TWB clocks before RB is trusted
// WAIT_RB | wait for synchronized RB high
// DONE    | one-clock done pulse, CE released
module nand_op_sequencer #(
    parameter int WE_LOW  = 2,
    parameter int WE_HIGH = 2,
    parameter int TWB     = 4
`ifdef NAND_RB_TIMEOUT_EN
    ,
    parameter int RB_TIMEOUT = 1024
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    nand_op_sequencer_if.slave        host,
    input  logic                      RB,
    output logic                      CE,
    output logic                      CLE,
    output logic                      ALE,
    output logic                      WE,
    output logic [7:0]                IOX
`ifdef NAND_RB_TIMEOUT_EN
    ,
    output logic                      timeout
`endif
);

    localparam logic [3:0]  BUS_LAST = 4'(WE_LOW + WE_HIGH - 1);
    localparam logic [3:0]  WE_LOW_C = 4'(WE_LOW);
    localparam logic [15:0] TWB_LOAD = 16'(TWB - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_ADDR,
        S_CMD2,
        S_WAIT_WB,
        S_WAIT_RB,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cyc_cnt;
    logic [3:0]  byte_idx;
    logic [3:0]  addr_sel;
    logic [15:0] wb_tmr;
    logic        op_q;
    logic [39:0] addr_q;
    logic        rb_meta, rb_sync;
    logic        last_cyc, last_byte, in_bus, we_phase;
    logic [7:0]  addr_byte;

`ifdef NAND_RB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic        to_hit, to_flag;
    assign to_hit  = (to_cnt == 16'(RB_TIMEOUT - 1));
    assign timeout = (state == S_DONE) && to_flag;
`endif

    assign last_cyc  = (cyc_cnt == BUS_LAST);
    assign last_byte = (byte_idx == (op_q ? 4'd2 : 4'd4));
    assign in_bus    = (state == S_CMD1) || (state == S_ADDR) || (state == S_CMD2);
    assign we_phase  = (cyc_cnt >= WE_LOW_C);
    // Erase skips the two column bytes, so its row bytes start at index 2.
    assign addr_sel  = op_q ? (byte_idx + 4'd2) : byte_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cyc_cnt  <= 4'd0;
            byte_idx <= 4'd0;
            wb_tmr   <= 16'd0;
            op_q     <= 1'b0;
            addr_q   <= 40'd0;
            rb_meta  <= 1'b0;
            rb_sync  <= 1'b0;
`ifdef NAND_RB_TIMEOUT_EN
            to_cnt   <= 16'd0;
            to_flag  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            rb_meta <= RB;
            rb_sync <= rb_meta;
            if (state == S_IDLE && host.req_valid) begin
                op_q   <= host.req_op;
                addr_q <= host.req_addr;
            end
            if (in_bus && !last_cyc) cyc_cnt <= cyc_cnt + 4'd1;
            else                     cyc_cnt <= 4'd0;
            if (state != S_ADDR)     byte_idx <= 4'd0;
            else if (last_cyc)       byte_idx <= byte_idx + 4'd1;
            // Loaded throughout CMD2, counts down to zero across WAIT_WB.
            if (state == S_CMD2)     wb_tmr <= TWB_LOAD;
            else if (wb_tmr != 16'd0) wb_tmr <= wb_tmr - 16'd1;
`ifdef NAND_RB_TIMEOUT_EN
            if (state != S_WAIT_RB)  to_cnt <= 16'd0;
            else                     to_cnt <= to_cnt + 16'd1;
            to_flag <= (state == S_WAIT_RB) && !rb_sync && to_hit;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (host.req_valid)          state_nxt = S_CMD1;
            S_CMD1:    if (last_cyc)                state_nxt = S_ADDR;
            S_ADDR:    if (last_cyc && last_byte)   state_nxt = S_CMD2;
            S_CMD2:    if (last_cyc)                state_nxt = S_WAIT_WB;
            S_WAIT_WB: if (wb_tmr == 16'd0)         state_nxt = S_WAIT_RB;
            S_WAIT_RB: begin
                if (rb_sync)                        state_nxt = S_DONE;
`ifdef NAND_RB_TIMEOUT_EN
                else if (to_hit)                    state_nxt = S_DONE;
`endif
            end
            S_DONE:                                 state_nxt = S_IDLE;
            default:                                state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        addr_byte = 8'h00;
        case (addr_sel)
            4'd0:    addr_byte = addr_q[7:0];
            4'd1:    addr_byte = addr_q[15:8];
            4'd2:    addr_byte = addr_q[23:16];
            4'd3:    addr_byte = addr_q[31:24];
            4'd4:    addr_byte = addr_q[39:32];
            default: addr_byte = 8'h00;
        endcase
    end

    always_comb begin
        CE             = 1'b1;
        CLE            = 1'b0;
        ALE            = 1'b0;
        WE             = 1'b1;
        IOX            = 8'h00;
        host.busy      = 1'b0;
        host.done      = 1'b0;
        host.req_ready = 1'b0;
        case (state)
            // Gated so the host never sees ready while reset is held.
            S_IDLE: host.req_ready = !rst;
            S_CMD1: begin
                CE        = 1'b0;
                CLE       = 1'b1;
                WE        = we_phase;
                IOX       = op_q ? 8'h60 : 8'h00;
                host.busy = 1'b1;
            end
            S_ADDR: begin
                CE        = 1'b0;
                ALE       = 1'b1;
                WE        = we_phase;
                IOX       = addr_byte;
                host.busy = 1'b1;
            end
            S_CMD2: begin
                CE        = 1'b0;
                CLE       = 1'b1;
                WE        = we_phase;
                IOX       = op_q ? 8'hD0 : 8'h30;
                host.busy = 1'b1;
            end
            S_WAIT_WB, S_WAIT_RB: begin
                CE        = 1'b0;
                host.busy = 1'b1;
            end
            S_DONE: host.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// tb_nand_op_sequencer: self-checking bench for nand_op_sequencer.
// A table of request vectors carries the expected bus byte sequence and
// done latency; expected bus cycles go into a scoreboard queue when a request
// is driven and are popped at every WE rising edge. Hand-written sequences
// cover the RB busy wait, a mid-operation reset and back-to-back requests.
module tb_nand_op_sequencer;

    localparam int WE_LOW  = 2;
    localparam int WE_HIGH = 2;
    localparam int TWB     = 4;

    typedef struct packed {
        logic [7:0] iox;
        logic       cle;
        logic       ale;
    } bus_t;

    typedef struct packed {
        logic        op;
        logic [39:0] addr;
        logic [3:0]  n;
        logic [55:0] seq;
        logic [7:0]  lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       RB  = 1'b1;
    logic       CE, CLE, ALE, WE;
    logic [7:0] IOX;
`ifdef NAND_RB_TIMEOUT_EN
    logic       timeout;
`endif

    nand_op_sequencer_if bus();

    nand_op_sequencer #(
        .WE_LOW (WE_LOW),
        .WE_HIGH(WE_HIGH),
        .TWB    (TWB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .host(bus.slave),
        .RB  (RB),
        .CE  (CE),
        .CLE (CLE),
        .ALE (ALE),
        .WE  (WE),
        .IOX (IOX)
`ifdef NAND_RB_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    int   n_cmp      = 0;
    int   n_err      = 0;
    int   cyc        = 0;
    int   first_fall = -1;
    int   last_fall  = -1;
    int   low_cnt    = 0;
    int   rises      = 0;
    int   ce_bad     = 0;
    int   rdy_bad    = 0;
    logic prev_we    = 1'b1;
    bus_t fall_v     = '0;
    bus_t exp_q[$];
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: sample on the falling edge and run the bus monitor.
    task automatic step();
        bus_t now_v;
        bus_t e;
        @(negedge clk);
        cyc++;
        now_v = {IOX, CLE, ALE};
        if (rst) begin
            prev_we = 1'b1;
            low_cnt = 0;
        end else begin
            if (!WE && prev_we) begin
                if (first_fall < 0) first_fall = cyc;
                else if (cyc - last_fall < 8)
                    check("bus_cycle_len", cyc - last_fall, WE_LOW + WE_HIGH);
                last_fall = cyc;
                fall_v    = now_v;
                low_cnt   = 1;
            end else if (!WE) begin
                low_cnt++;
            end
            if (WE && !prev_we) begin
                rises++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_bus_cycle: got iox=0x%0h cle=%0b ale=%0b, expected no bus cycle (cycle %0d)",
                             IOX, CLE, ALE, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("bus_byte", {fall_v, now_v, 4'(low_cnt)}, {e, e, 4'(WE_LOW)});
                end
            end
            prev_we = WE;
            if (bus.busy && CE)            ce_bad++;
            if (bus.busy && bus.req_ready) rdy_bad++;
        end
    endtask

    task automatic push_expected(input vec_t v);
        bus_t e;
        for (int i = 0; i < int'(v.n); i++) begin
            e.iox = v.seq[55 - 8*i -: 8];
            e.cle = (i == 0) || (i == int'(v.n) - 1);
            e.ale = !e.cle;
            exp_q.push_back(e);
        end
    endtask

    // rb_hold > 0: RB low from the request until rb_hold clocks after WAIT_WB entry.
    task automatic do_txn(input vec_t v, input int rb_hold);
        int done_cyc   = -1;
        int rise_cyc   = -1;
        int extra_done = 0;
        push_expected(v);
        first_fall = -1;
        ce_bad     = 0;
        if (rb_hold > 0) RB = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_addr  = v.addr;
        step();
        check("busy_after_accept", {bus.busy, bus.req_ready}, 2'b10);
        bus.req_valid = 1'b0;
        bus.req_op    = ~v.op;
        bus.req_addr  = ~v.addr;
        for (int t = 0; t < 3000 && done_cyc < 0; t++) begin
            if (rb_hold > 0 && rise_cyc < 0 && exp_q.size() == 0) begin
                repeat (rb_hold + WE_HIGH) begin
                    step();
                    if (bus.done) extra_done++;
                end
                RB       = 1'b1;
                rise_cyc = cyc;
            end
            step();
            if (bus.done) done_cyc = cyc;
        end
        check("done_seen", done_cyc >= 0, 1'b1);
        if (done_cyc >= 0) begin
            if (rb_hold > 0) begin
                check("done_after_rb_rise", done_cyc - rise_cyc, 3);
                check("early_done", extra_done, 0);
            end else begin
                check("done_latency", done_cyc - first_fall, v.lat);
            end
            check("bytes_left", exp_q.size(), 0);
            check("ce_low_while_busy", ce_bad, 0);
            check("done_pins", {CE, bus.busy, bus.req_ready}, 3'b100);
            step();
            check("idle_after_done", {bus.done, bus.req_ready, bus.busy, CE}, 4'b0101);
        end
        exp_q.delete();
        RB = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ab_done;
        int n_acc, n_done, done1, acc2;

        bus.req_valid = 1'b0;
        bus.req_op    = 1'b0;
        bus.req_addr  = 40'd0;

        vecs[0] = '{op: 1'b0, addr: 40'h12_3456_789A, n: 4'd7,
                    seq: {8'h00, 8'h9A, 8'h78, 8'h56, 8'h34, 8'h12, 8'h30}, lat: 8'd33};
        vecs[1] = '{op: 1'b1, addr: 40'hAB_CDEF_1234, n: 4'd5,
                    seq: {8'h60, 8'hEF, 8'hCD, 8'hAB, 8'hD0, 16'h0000}, lat: 8'd25};
        vecs[2] = '{op: 1'b0, addr: 40'hFF_0000_00FF, n: 4'd7,
                    seq: {8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h30}, lat: 8'd33};
        vecs[3] = '{op: 1'b1, addr: 40'h00_0001_FFFF, n: 4'd5,
                    seq: {8'h60, 8'h01, 8'h00, 8'h00, 8'hD0, 16'h0000}, lat: 8'd25};

        // Reset held for three clocks.
        rst = 1'b1;
        repeat (3) step();
        check("reset_outputs", {CE, WE, CLE, ALE, IOX, bus.busy, bus.done, bus.req_ready},
              {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        step();
        check("ready_after_reset", {bus.req_ready, bus.busy, bus.done}, 3'b100);

        for (int i = 0; i < 4; i++) do_txn(vecs[i], 0);

        // Busy wait on RB.
        do_txn(vecs[0], 50);

        // Reset during the third address byte.
        push_expected(vecs[0]);
        first_fall    = -1;
        rises         = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = vecs[0].op;
        bus.req_addr  = vecs[0].addr;
        step();
        bus.req_valid = 1'b0;
        for (int t = 0; t < 100 && rises < 3; t++) step();
        step();
        step();
        check("abort_point", {ALE, WE, IOX}, {1'b1, 1'b0, 8'h56});
        rst = 1'b1;
        exp_q.delete();
        step();
        check("abort_reset_outputs", {CE, WE, CLE, ALE, IOX, bus.busy, bus.done, bus.req_ready},
              {1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        step();
        check("ready_after_abort", {bus.req_ready, bus.busy}, 2'b10);
        ab_done = 0;
        repeat (40) begin
            step();
            if (bus.done) ab_done++;
        end
        check("abort_no_done", ab_done, 0);
        do_txn(vecs[0], 0);

        // Back-to-back with req_valid held high.
        push_expected(vecs[1]);
        push_expected(vecs[1]);
        first_fall    = -1;
        rdy_bad       = 0;
        n_acc         = 0;
        n_done        = 0;
        done1         = -1;
        acc2          = -1;
        bus.req_valid = 1'b1;
        bus.req_op    = vecs[1].op;
        bus.req_addr  = vecs[1].addr;
        for (int t = 0; t < 300 && n_done < 2; t++) begin
            if (bus.req_valid && bus.req_ready) begin
                n_acc++;
                if (n_acc == 2) acc2 = cyc;
            end
            step();
            if (bus.done) begin
                n_done++;
                if (n_done == 1) done1 = cyc;
                if (n_done == 2) bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        step();
        check("b2b_done_count", n_done, 2);
        check("b2b_accept_count", n_acc, 2);
        check("b2b_second_accept", acc2 - done1, 1);
        check("b2b_ready_while_busy", rdy_bad, 0);
        check("b2b_bytes_left", exp_q.size(), 0);
        check("b2b_idle", {bus.req_ready, bus.busy, CE}, 3'b101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
